// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP multiplier scheduler.
// WAIT is an uppercase enum literal here and is distinct from the lowercase wait keyword.
package fp_mul_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int FP_W = 32;
    localparam logic [7:0] EXP_BIAS = 8'd127;

endpackage

// File: rtl/fp_mul_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found after ptr, searching upward with wrap.
module rr_arbiter
    import fp_mul_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic                 any
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;

    // Scan from farthest to nearest so the closest requester after ptr overrides earlier hits.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N; i >= 1; i--) begin
            idx = PW'((int'(ptr) + i) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fp_mul_scheduler.sv
// Shares one FP multiplier among NREQ requesters: round-robin grant, start/done sequencing,
// watchdog abort and a held response per request.
module fp_mul_scheduler
    import fp_mul_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*FP_W-1:0]   req_op1,
    input  logic [NREQ*FP_W-1:0]   req_op2,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [FP_W-1:0]        rsp_result,
    output logic                   rsp_overflow,
    output logic                   rsp_timeout,
    output logic                   mul_start,
    output logic [FP_W-1:0]        mul_op1,
    output logic [FP_W-1:0]        mul_op2,
    input  logic [FP_W-1:0]        mul_result,
    input  logic                   mul_done,
    input  logic                   mul_overflow
);

    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   cur_id;
    logic [PW-1:0]   win_id;
    logic [TW-1:0]   timer;
    logic [NREQ-1:0] gnt;
    logic            any_req;
    logic [FP_W-1:0] sel_op1;
    logic [FP_W-1:0] sel_op2;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .any (any_req)
    );

    always_comb begin
        win_id  = '0;
        sel_op1 = '0;
        sel_op2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_id  = PW'(i);
                sel_op1 = req_op1[FP_W*i +: FP_W];
                sel_op2 = req_op2[FP_W*i +: FP_W];
            end
        end
    end

    // Suppressed during reset so a requester never drops a request the FSM will not take.
    assign req_ready = (state == IDLE && !rst) ? gnt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= PW'(NREQ - 1);
            cur_id       <= '0;
            timer        <= '0;
            mul_start    <= 1'b0;
            mul_op1      <= '0;
            mul_op2      <= '0;
            rsp_valid    <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cur_id    <= win_id;
                        mul_op1   <= sel_op1;
                        mul_op2   <= sel_op2;
                        mul_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A completion in the expiry cycle still delivers the real product.
                    if (mul_done) begin
                        rsp_result   <= mul_result;
                        rsp_overflow <= mul_overflow;
                        rsp_timeout  <= 1'b0;
                        rsp_valid    <= NREQ'(1) << cur_id;
                        mul_op1      <= '0;
                        mul_op2      <= '0;
                        state        <= RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        rsp_result   <= '0;
                        rsp_overflow <= 1'b0;
                        rsp_timeout  <= 1'b1;
                        rsp_valid    <= NREQ'(1) << cur_id;
                        mul_op1      <= '0;
                        mul_op2      <= '0;
                        state        <= RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready[cur_id]) begin
                        rsp_valid    <= '0;
                        rsp_result   <= '0;
                        rsp_overflow <= 1'b0;
                        rsp_timeout  <= 1'b0;
                        rr_ptr       <= cur_id;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Directed bench for fp_mul_scheduler; the bench itself plays a latency-1 multiplier.
module tb_fp_mul_scheduler;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_op1;
    logic [127:0] req_op2;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [31:0]  rsp_result;
    logic         rsp_overflow;
    logic         rsp_timeout;
    logic         mul_start;
    logic [31:0]  mul_op1;
    logic [31:0]  mul_op2;
    logic [31:0]  mul_result;
    logic         mul_done;
    logic         mul_overflow;

    logic [31:0] op1_tab  [4];
    logic [31:0] op2_tab  [4];
    logic [31:0] prod_tab [4];

    int checks = 0;
    int errors = 0;

    fp_mul_scheduler #(.NREQ(4), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_timeout  (rsp_timeout),
        .mul_start    (mul_start),
        .mul_op1      (mul_op1),
        .mul_op2      (mul_op2),
        .mul_result   (mul_result),
        .mul_done     (mul_done),
        .mul_overflow (mul_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] rready,
                                 input logic done, input logic [31:0] mres, input logic movf);
        req_valid    = valid;
        rsp_ready    = rready;
        mul_done     = done;
        mul_result   = mres;
        mul_overflow = movf;
        for (int i = 0; i < 4; i++) begin
            req_op1[32*i +: 32] = op1_tab[i];
            req_op2[32*i +: 32] = op2_tab[i];
        end
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    // One full transaction starting in an IDLE cycle: grant, issue, one-cycle multiply, response.
    task automatic do_txn(input int id, input bit keep, input logic exp_ovf);
        logic [3:0] oh;
        oh = 4'(1 << id);
        checkOutput("grant", 32'(req_ready), 32'(oh));
        tick();
        applyStimulus(keep ? req_valid : (req_valid & ~oh), 4'b0000, 1'b0, 32'h0, 1'b0);
        checkOutput("mul_start", 32'(mul_start), 32'd1);
        checkOutput("mul_op1", mul_op1, op1_tab[id]);
        checkOutput("mul_op2", mul_op2, op2_tab[id]);
        checkOutput("no_grant_issue", 32'(req_ready), 32'd0);
        tick();
        checkOutput("start_pulse", 32'(mul_start), 32'd0);
        checkOutput("op_hold", mul_op1, op1_tab[id]);
        applyStimulus(req_valid, 4'b0000, 1'b1, prod_tab[id], exp_ovf);
        tick();
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(oh));
        checkOutput("rsp_result", rsp_result, prod_tab[id]);
        checkOutput("rsp_overflow", 32'(rsp_overflow), 32'(exp_ovf));
        checkOutput("rsp_timeout", 32'(rsp_timeout), 32'd0);
        checkOutput("op_clear", mul_op1, 32'd0);
        applyStimulus(req_valid, oh, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("rsp_drop", 32'(rsp_valid), 32'd0);
        applyStimulus(req_valid, 4'b0000, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        // 1.25*1.5, 2*2, 3*2, 4*0.5
        op1_tab  = '{32'h3FA00000, 32'h40000000, 32'h40400000, 32'h40800000};
        op2_tab  = '{32'h3FC00000, 32'h40000000, 32'h40000000, 32'h3F000000};
        prod_tab = '{32'h3FF00000, 32'h40800000, 32'h40C00000, 32'h40000000};
        rst = 1'b1;
        applyStimulus(4'b1111, 4'b0000, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_mul_start", 32'(mul_start), 32'd0);
        checkOutput("rst_mul_op1", mul_op1, 32'd0);
        checkOutput("rst_rsp_result", rsp_result, 32'd0);
        checkOutput("rst_flags", {30'd0, rsp_overflow, rsp_timeout}, 32'd0);

        $display("[TB] req1+req2 from reset, then req3+req0");
        applyStimulus(4'b0110, 4'b0000, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        do_txn(1, 1'b0, 1'b0);
        do_txn(2, 1'b0, 1'b0);
        applyStimulus(4'b1001, 4'b0000, 1'b0, 32'h0, 1'b0);
        do_txn(3, 1'b0, 1'b0);
        do_txn(0, 1'b0, 1'b0);

        $display("[TB] single req0 1.25*1.5");
        applyStimulus(4'b0001, 4'b0000, 1'b0, 32'h0, 1'b0);
        do_txn(0, 1'b0, 1'b0);

        $display("[TB] overflow pass-through");
        op1_tab[3]  = 32'h7F000000;
        op2_tab[3]  = 32'h7F000000;
        prod_tab[3] = 32'h7F800000;
        applyStimulus(4'b1000, 4'b0000, 1'b0, 32'h0, 1'b0);
        do_txn(3, 1'b0, 1'b1);
        op1_tab[3]  = 32'h40800000;
        op2_tab[3]  = 32'h3F000000;
        prod_tab[3] = 32'h40000000;

        $display("[TB] watchdog timeout on req2, rsp_ready raised early");
        applyStimulus(4'b0100, 4'b0100, 1'b0, 32'h0, 1'b0);
        checkOutput("to_grant", 32'(req_ready), 32'h4);
        tick();
        applyStimulus(4'b0000, 4'b0100, 1'b0, 32'hDEADBEEF, 1'b1);
        checkOutput("to_start", 32'(mul_start), 32'd1);
        for (int i = 0; i < 15; i++) begin
            tick();
            checkOutput("to_wait", 32'(rsp_valid), 32'd0);
        end
        tick();
        checkOutput("to_rsp_valid", 32'(rsp_valid), 32'h4);
        checkOutput("to_timeout", 32'(rsp_timeout), 32'd1);
        checkOutput("to_result", rsp_result, 32'd0);
        checkOutput("to_overflow", 32'(rsp_overflow), 32'd0);
        tick();
        checkOutput("to_drop", 32'(rsp_valid), 32'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0);

        $display("[TB] response stall with competing request");
        applyStimulus(4'b0001, 4'b0000, 1'b0, 32'h0, 1'b0);
        checkOutput("st_grant", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b1, prod_tab[0], 1'b0);
        tick();
        applyStimulus(4'b0010, 4'b1110, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("st_valid", 32'(rsp_valid), 32'h1);
            checkOutput("st_result", rsp_result, 32'h3FF00000);
            checkOutput("st_no_grant", 32'(req_ready), 32'd0);
            tick();
        end
        applyStimulus(4'b0010, 4'b0001, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(4'b0010, 4'b0000, 1'b0, 32'h0, 1'b0);
        checkOutput("st_drop", 32'(rsp_valid), 32'd0);
        do_txn(1, 1'b0, 1'b0);

        $display("[TB] reset during WAIT");
        applyStimulus(4'b0100, 4'b0000, 1'b0, 32'h0, 1'b0);
        checkOutput("mr_grant", 32'(req_ready), 32'h4);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("mr_wait_op", mul_op1, op1_tab[2]);
        rst = 1'b1;
        applyStimulus(4'b1111, 4'b0000, 1'b0, 32'h0, 1'b0);
        checkOutput("mr_op1", mul_op1, 32'd0);
        checkOutput("mr_op2", mul_op2, 32'd0);
        checkOutput("mr_ready", 32'(req_ready), 32'd0);
        tick();
        checkOutput("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("mr_first_grant", 32'(req_ready), 32'h1);

        $display("[TB] all four continuously valid");
        do_txn(0, 1'b1, 1'b0);
        do_txn(1, 1'b1, 1'b0);
        do_txn(2, 1'b1, 1'b0);
        do_txn(3, 1'b1, 1'b0);
        do_txn(0, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
